// File: rtl/dec_ram_ctrl_pkg.sv
// Shared types and constants for the DEC_RAM ping-pong controller.
package dec_ram_ctrl_pkg;

  typedef enum logic {GNT_WRITE = 1'b0, GNT_READ = 1'b1} grant_t;

  typedef logic bank_sel_t;

  localparam int OUT_FIFO_DEPTH = 2;
  localparam int OUT_FIFO_CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

endpackage

// File: rtl/dec_out_fifo.sv
// Small output FIFO holding read words (data + last tag) between DEC_RAM and the consumer.
module dec_out_fifo
  import dec_ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic [OUT_FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;

  logic [WIDTH-1:0]          mem_reg [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg;
  logic [PTR_W-1:0]          rd_ptr_reg;
  logic [OUT_FIFO_CNT_W-1:0] count_reg;
  logic                      do_push;
  logic                      do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = pop && (count_reg != '0);
    do_push = push && ((count_reg != OUT_FIFO_CNT_W'(OUT_FIFO_DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + OUT_FIFO_CNT_W'(do_push) - OUT_FIFO_CNT_W'(do_pop);
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/dec_ram_pingpong_ctrl.sv
// Two-bank ping-pong controller for DEC_RAM: fills one bank from the decoder while the
// other is drained to the output stream, sharing the single RAM address port round-robin.
module dec_ram_pingpong_ctrl
  import dec_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in [0:1],
  output logic [1:0]            ram_we,
  output logic [1:0]            ram_cs,
  input  logic [DATA_WIDTH-1:0] ram_data_out [0:1],
  output logic [1:0]            bank_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  bank_sel_t                 fill_sel_reg, fill_sel_next;
  bank_sel_t                 rd_sel_reg, rd_sel_next;
  logic [ADDR_WIDTH-1:0]     wr_cnt_reg, wr_cnt_next;
  logic [ADDR_WIDTH-1:0]     rd_cnt_reg, rd_cnt_next;
  logic [1:0]                bank_full_reg, bank_full_next;
  grant_t                    rr_last_reg, rr_last_next;
  logic                      rd_pend_reg, rd_pend_next;
  bank_sel_t                 rd_pend_bank_reg, rd_pend_bank_next;
  logic                      rd_pend_last_reg, rd_pend_last_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;

  logic [OUT_FIFO_CNT_W-1:0] fifo_count;
  logic [OUT_FIFO_CNT_W:0]   credit_used;
  logic [DATA_WIDTH:0]       fifo_push_data;
  logic [DATA_WIDTH:0]       fifo_pop_data;
  logic                      wr_ok;
  logic                      rd_ok;
  logic                      wr_gnt;
  logic                      rd_gnt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wdata
      assign ram_data_in[gi] = in_data;
    end
  endgenerate

  // Reads are credit-limited so an in-flight word always finds a free FIFO slot.
  always_comb begin
    credit_used = {1'b0, fifo_count} + (OUT_FIFO_CNT_W + 1)'(rd_pend_reg);
    wr_ok       = !bank_full_reg[fill_sel_reg];
    rd_ok       = bank_full_reg[rd_sel_reg] &&
                  (credit_used < (OUT_FIFO_CNT_W + 1)'(OUT_FIFO_DEPTH));
    in_ready    = rst_n && wr_ok && !(rd_ok && (rr_last_reg == GNT_WRITE));
    wr_gnt      = in_valid && in_ready;
    rd_gnt      = rst_n && rd_ok && !wr_gnt;
  end

  always_comb begin
    ram_cs      = 2'b00;
    ram_we      = 2'b00;
    ram_address = addr_reg;
    if (wr_gnt) begin
      ram_cs[fill_sel_reg] = 1'b1;
      ram_we[fill_sel_reg] = 1'b1;
      ram_address          = wr_cnt_reg;
    end else if (rd_gnt) begin
      ram_cs[rd_sel_reg] = 1'b1;
      ram_address        = rd_cnt_reg;
    end
  end

  always_comb begin
    fill_sel_next     = fill_sel_reg;
    rd_sel_next       = rd_sel_reg;
    wr_cnt_next       = wr_cnt_reg;
    rd_cnt_next       = rd_cnt_reg;
    bank_full_next    = bank_full_reg;
    rr_last_next      = rr_last_reg;
    rd_pend_next      = rd_gnt;
    rd_pend_bank_next = rd_sel_reg;
    rd_pend_last_next = (rd_cnt_reg == LAST_ADDR);
    if (wr_gnt) begin
      rr_last_next = GNT_WRITE;
      if (wr_cnt_reg == LAST_ADDR) begin
        wr_cnt_next                  = '0;
        bank_full_next[fill_sel_reg] = 1'b1;
        fill_sel_next                = ~fill_sel_reg;
      end else begin
        wr_cnt_next = wr_cnt_reg + ADDR_WIDTH'(1);
      end
    end
    if (rd_gnt) begin
      rr_last_next = GNT_READ;
      if (rd_cnt_reg == LAST_ADDR) begin
        rd_cnt_next                = '0;
        bank_full_next[rd_sel_reg] = 1'b0;
        rd_sel_next                = ~rd_sel_reg;
      end else begin
        rd_cnt_next = rd_cnt_reg + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_sel_reg     <= 1'b0;
      rd_sel_reg       <= 1'b0;
      wr_cnt_reg       <= '0;
      rd_cnt_reg       <= '0;
      bank_full_reg    <= 2'b00;
      rr_last_reg      <= GNT_READ;
      rd_pend_reg      <= 1'b0;
      rd_pend_bank_reg <= 1'b0;
      rd_pend_last_reg <= 1'b0;
      addr_reg         <= '0;
    end else begin
      fill_sel_reg     <= fill_sel_next;
      rd_sel_reg       <= rd_sel_next;
      wr_cnt_reg       <= wr_cnt_next;
      rd_cnt_reg       <= rd_cnt_next;
      bank_full_reg    <= bank_full_next;
      rr_last_reg      <= rr_last_next;
      rd_pend_reg      <= rd_pend_next;
      rd_pend_bank_reg <= rd_pend_bank_next;
      rd_pend_last_reg <= rd_pend_last_next;
      addr_reg         <= ram_address;
    end
  end

  assign fifo_push_data = {rd_pend_last_reg, ram_data_out[rd_pend_bank_reg]};

  dec_out_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend_reg),
    .push_data(fifo_push_data),
    .pop      (out_valid && out_ready),
    .pop_data (fifo_pop_data),
    .count    (fifo_count)
  );

  assign out_valid = rst_n && (fifo_count != '0);
  assign out_data  = fifo_pop_data[DATA_WIDTH-1:0];
  assign out_last  = fifo_pop_data[DATA_WIDTH];
  assign bank_full = bank_full_reg;

endmodule

// File: tb/tb_dec_ram_pingpong_ctrl.sv
// Directed bench for dec_ram_pingpong_ctrl with a two-bank registered-read RAM model.
module tb_dec_ram_pingpong_ctrl;

  localparam int DW = 4;
  localparam int AW = 3;
  localparam int FL = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in [0:1];
  logic [1:0]    ram_we;
  logic [1:0]    ram_cs;
  logic [DW-1:0] ram_data_out [0:1];
  logic [1:0]    bank_full;

  dec_ram_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_cs(ram_cs),
    .ram_data_out(ram_data_out), .bank_full(bank_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] mem [0:1][0:7];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (ram_cs[b]) begin
        if (ram_we[b]) mem[b][ram_address] <= ram_data_in[b];
        else ram_data_out[b] <= mem[b][ram_address];
      end
    end
  end

  int            n_checks, n_pass;
  int            cyc, n_rd, n_pop, proto_err, fifo_err, last_wr_cyc;
  logic          last_acc;
  logic [DW:0]   out_q[$];
  int            out_cyc_q[$];
  logic          wr_bank_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int            rd_cyc_q[$];
  int            gnt_q[$];
  logic [DW-1:0] words [0:15];

  task automatic clear_logs();
    out_q.delete(); out_cyc_q.delete(); wr_bank_q.delete(); wr_addr_q.delete();
    rd_cyc_q.delete(); gnt_q.delete();
    cyc = 0; n_rd = 0; n_pop = 0; last_wr_cyc = -100;
  endtask

  // One clock: observe just after the negedge-driven inputs settle, then advance to next negedge.
  task automatic tick();
    int gnt;
    #1;
    cyc++;
    last_acc = 1'b0;
    if (rst_n) begin
      gnt = 0;
      if (ram_cs == 2'b11) proto_err++;
      if ((ram_we & ~ram_cs) != 2'b00) proto_err++;
      if (ram_we != 2'b00) begin
        gnt = 1;
        wr_bank_q.push_back(ram_we[1]);
        wr_addr_q.push_back(ram_address);
        last_wr_cyc = cyc;
        if (!(in_valid && in_ready)) proto_err++;
      end else if (ram_cs != 2'b00) begin
        gnt = 2;
        n_rd++;
        rd_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        if (ram_we == 2'b00) proto_err++;
        if (ram_data_in[0] !== in_data || ram_data_in[1] !== in_data) proto_err++;
      end
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        out_cyc_q.push_back(cyc);
        n_pop++;
      end
      if (n_rd - n_pop > 2) fifo_err++;
      gnt_q.push_back(gnt);
    end
    @(negedge clk);
  endtask

  function automatic logic ready_for(input int mode);
    return (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : cyc[0];
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic drive(input int n, input int mode, input int max_cyc, output int sent);
    int c;
    sent = 0; c = 0;
    while (sent < n && c < max_cyc) begin
      in_valid = 1'b1; in_data = words[sent]; out_ready = ready_for(mode);
      tick();
      if (last_acc) sent++;
      c++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int mode, input int max_cyc);
    int c;
    c = 0;
    while (out_q.size() < n && c < max_cyc) begin
      out_ready = ready_for(mode);
      tick();
      c++;
    end
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h1; out_ready = 1'b1;
    tick(); tick();
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (ram_we !== 2'b00) $display("FAIL rst_ram_we: got %b expected 00", ram_we); else n_pass++;
    n_checks++; if (ram_cs !== 2'b00) $display("FAIL rst_ram_cs: got %b expected 00", ram_cs); else n_pass++;
    rst_n = 1'b1; in_valid = 1'b0;
    clear_logs();
    #1;
    n_checks++; if (bank_full !== 2'b00) $display("FAIL rst_bank_full: got %b expected 00", bank_full); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); else n_pass++;
    in_valid = 1'b1;
    #1;
    n_checks++; if (ram_cs !== 2'b01) $display("FAIL first_wr_cs: got %b expected 01", ram_cs); else n_pass++;
    n_checks++; if (ram_we !== 2'b01) $display("FAIL first_wr_we: got %b expected 01", ram_we); else n_pass++;
    n_checks++; if (ram_address !== 3'd0) $display("FAIL first_wr_addr: got %0d expected 0", ram_address); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int sent;
    logic [DW:0] exp;
    do_reset(2);
    words[0] = 4'h1; words[1] = 4'h0; words[2] = 4'h1; words[3] = 4'h1;
    drive(4, 0, 40, sent);
    n_checks++; if (sent !== 4) $display("FAIL sf_sent: got %0d expected 4", sent); else n_pass++;
    n_checks++; if (bank_full !== 2'b01) $display("FAIL sf_bank_full: got %b expected 01", bank_full); else n_pass++;
    drain(4, 0, 40);
    n_checks++; if (out_q.size() != 4) $display("FAIL sf_out_count: got %0d expected 4", out_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wr_bank_q.size(); i++) begin
      n_checks++;
      if (wr_bank_q[i] !== 1'b0 || wr_addr_q[i] !== AW'(i))
        $display("FAIL sf_wr_%0d: got bank %b addr %0d expected bank 0 addr %0d", i, wr_bank_q[i], wr_addr_q[i], i);
      else n_pass++;
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      exp = {(i == 3), words[i]};
      n_checks++;
      if (out_q[i] !== exp) $display("FAIL sf_out_%0d: got %h expected %h", i, out_q[i], exp); else n_pass++;
    end
    n_checks++;
    if (out_cyc_q.size() == 0 || out_cyc_q[0] != last_wr_cyc + 3)
      $display("FAIL sf_latency: got cycle %0d expected %0d", (out_cyc_q.size() > 0) ? out_cyc_q[0] : -1, last_wr_cyc + 3);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sent;
    logic [DW:0] exp;
    logic [DW-1:0] v [12] = '{4'h3, 4'h8, 4'hD, 4'h1, 4'hE, 4'h6, 4'hB, 4'h0, 4'h9, 4'h4, 4'hF, 4'h2};
    int exp_gnt [16] = '{1, 1, 1, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
    do_reset(2);
    for (int i = 0; i < 12; i++) words[i] = v[i];
    drive(12, 0, 100, sent);
    n_checks++; if (sent !== 12) $display("FAIL b2b_sent: got %0d expected 12", sent); else n_pass++;
    drain(12, 0, 100);
    for (int i = 0; i < 16 && i < gnt_q.size(); i++) begin
      n_checks++;
      if (gnt_q[i] != exp_gnt[i]) $display("FAIL b2b_grant_%0d: got %0d expected %0d", i, gnt_q[i], exp_gnt[i]);
      else n_pass++;
    end
    for (int i = 0; i < 12 && i < wr_bank_q.size(); i++) begin
      n_checks++;
      if (wr_bank_q[i] !== ((i / 4) == 1) || wr_addr_q[i] !== AW'(i % 4))
        $display("FAIL b2b_wr_%0d: got bank %b addr %0d expected bank %0d addr %0d", i, wr_bank_q[i], wr_addr_q[i], (i / 4) == 1, i % 4);
      else n_pass++;
    end
    n_checks++; if (out_q.size() != 12) $display("FAIL b2b_out_count: got %0d expected 12", out_q.size()); else n_pass++;
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      exp = {((i % 4) == 3), words[i]};
      n_checks++;
      if (out_q[i] !== exp) $display("FAIL b2b_out_%0d: got %h expected %h", i, out_q[i], exp); else n_pass++;
    end
    n_checks++; if (proto_err != 0) $display("FAIL b2b_protocol: got %0d errors expected 0", proto_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    int sent, acc_cyc;
    logic [DW:0] exp;
    logic [DW-1:0] v [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h0, 4'h9, 4'h6};
    do_reset(2);
    for (int i = 0; i < 8; i++) words[i] = v[i];
    drive(8, 1, 60, sent);
    n_checks++; if (sent !== 8) $display("FAIL bp_sent: got %0d expected 8", sent); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b expected 0", k, in_ready); else n_pass++;
      n_checks++; if (bank_full !== 2'b11) $display("FAIL bp_bank_full_%0d: got %b expected 11", k, bank_full); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d: got %b expected 1", k, out_valid); else n_pass++;
      tick();
    end
    n_checks++; if (n_rd != 2) $display("FAIL bp_reads_held: got %0d expected 2", n_rd); else n_pass++;
    acc_cyc = -1;
    for (int k = 0; k < 40 && acc_cyc < 0; k++) begin
      in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
      tick();
      if (last_acc) acc_cyc = cyc;
    end
    in_valid = 1'b0;
    n_checks++;
    if (rd_cyc_q.size() < 4 || acc_cyc != rd_cyc_q[3] + 1)
      $display("FAIL bp_ready_rise: got cycle %0d expected %0d", acc_cyc, (rd_cyc_q.size() >= 4) ? rd_cyc_q[3] + 1 : -1);
    else n_pass++;
    drain(8, 0, 80);
    n_checks++; if (out_q.size() != 8) $display("FAIL bp_out_count: got %0d expected 8", out_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      exp = {((i % 4) == 3), words[i]};
      n_checks++;
      if (out_q[i] !== exp) $display("FAIL bp_out_%0d: got %h expected %h", i, out_q[i], exp); else n_pass++;
    end
  endtask

  task automatic test_ready_toggle();
    int sent;
    logic [DW:0] exp;
    logic [DW-1:0] v [12] = '{4'h2, 4'h9, 4'h4, 4'hF, 4'h1, 4'hC, 4'h7, 4'h8, 4'h0, 4'hB, 4'h5, 4'hE};
    do_reset(2);
    for (int i = 0; i < 12; i++) words[i] = v[i];
    drive(12, 2, 200, sent);
    n_checks++; if (sent !== 12) $display("FAIL tog_sent: got %0d expected 12", sent); else n_pass++;
    drain(12, 2, 200);
    n_checks++; if (out_q.size() != 12) $display("FAIL tog_out_count: got %0d expected 12", out_q.size()); else n_pass++;
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      exp = {((i % 4) == 3), words[i]};
      n_checks++;
      if (out_q[i] !== exp) $display("FAIL tog_out_%0d: got %h expected %h", i, out_q[i], exp); else n_pass++;
    end
    n_checks++; if (fifo_err != 0) $display("FAIL tog_fifo_depth: got %0d overruns expected 0", fifo_err); else n_pass++;
    n_checks++; if (proto_err != 0) $display("FAIL tog_protocol: got %0d errors expected 0", proto_err); else n_pass++;
  endtask

  // Relies on the previous scenario leaving both selectors pointing at bank 1.
  task automatic test_mid_reset();
    int sent;
    logic [DW:0] exp;
    logic [DW-1:0] v [6] = '{4'h6, 4'h3, 4'hA, 4'hD, 4'hB, 4'hC};
    logic [DW-1:0] w [4] = '{4'h5, 4'hA, 4'h3, 4'hE};
    for (int i = 0; i < 6; i++) words[i] = v[i];
    drive(6, 1, 40, sent);
    n_checks++; if (bank_full !== 2'b10) $display("FAIL mr_pre_bank_full: got %b expected 10", bank_full); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mr_pre_out_valid: got %b expected 1", out_valid); else n_pass++;
    do_reset(1);
    n_checks++; if (bank_full !== 2'b00) $display("FAIL mr_bank_full: got %b expected 00", bank_full); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b expected 0", out_valid); else n_pass++;
    for (int i = 0; i < 4; i++) words[i] = w[i];
    drive(4, 0, 40, sent);
    n_checks++; if (sent !== 4) $display("FAIL mr_sent: got %0d expected 4", sent); else n_pass++;
    drain(4, 0, 40);
    for (int i = 0; i < 4 && i < wr_bank_q.size(); i++) begin
      n_checks++;
      if (wr_bank_q[i] !== 1'b0 || wr_addr_q[i] !== AW'(i))
        $display("FAIL mr_wr_%0d: got bank %b addr %0d expected bank 0 addr %0d", i, wr_bank_q[i], wr_addr_q[i], i);
      else n_pass++;
    end
    n_checks++; if (out_q.size() != 4) $display("FAIL mr_out_count: got %0d expected 4", out_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      exp = {(i == 3), words[i]};
      n_checks++;
      if (out_q[i] !== exp) $display("FAIL mr_out_%0d: got %h expected %h", i, out_q[i], exp); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; proto_err = 0; fifo_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_logs();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_ready_toggle();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dec_ram_pingpong_ctrl.md
Name: dec_ram_pingpong_ctrl

Overview:
Ping-pong controller for the two-bank hard-decision RAM (DEC_RAM).
- The decoder streams decision words in, and the controller writes them into the current fill bank.
- An output stream reads completed frames from the other bank.
- DEC_RAM has a single shared address port, so the block also arbitrates that port between writer and reader, one access per cycle.
- It sits between the LDPC decision stage and the frame output interface.

Parameters:
DATA_WIDTH, 1, width of one decision word; matches DEC_RAM DATA_WIDTH.
ADDR_WIDTH, 8, DEC_RAM address width.
FRAME_LEN, 256, words per frame; legal range 2..2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  decoder word valid.
in_ready  out  1  controller can accept in_data this cycle.
in_data  in  DATA_WIDTH  decision word.
out_valid  out  1  output word valid.
out_ready  in  1  consumer accepts out_data.
out_data  out  DATA_WIDTH  frame word, ascending address order.
out_last  out  1  marks word FRAME_LEN-1 of a frame.
ram_address  out  ADDR_WIDTH  to DEC_RAM address.
ram_data_in  out  DATA_WIDTH x2 (unpacked [0:1])  both entries = in_data.
ram_we  out  2  per-bank write enable.
ram_cs  out  2  per-bank chip select.
ram_data_out  in  DATA_WIDTH x2 (unpacked [0:1])  from DEC_RAM; read data valid 1 cycle after cs&!we.
bank_full  out  2  bank holds a complete, not-yet-drained frame.

Behaviour:
- State:
  - fill_sel: bank being written.
  - rd_sel: bank being drained.
  - wr_cnt, rd_cnt: ADDR_WIDTH counters.
  - bank_full[1:0].
  - rr_last: last granted requester.
  - rd_pend plus rd_pend_last: an issued read that is in flight.
  - 2-entry output FIFO.
- Reset values: fill_sel=0, rd_sel=0, counters=0, bank_full=00, rr_last=READ (so write wins first contest), rd_pend=0, FIFO empty.
- Outputs during reset: out_valid=0, in_ready=0, ram_we=00, ram_cs=00. RAM contents are not cleared; both banks are treated empty.
- Write eligibility:
  - wr_ok = !bank_full[fill_sel].
- Read eligibility:
  - rd_ok = bank_full[rd_sel] && (fifo_count + rd_pend < 2).
- Arbitration, one RAM access per cycle:
  - Only one eligible: it wins.
  - Both eligible: the one not equal to rr_last wins.
  - rr_last updates only when a grant actually occurs.
- Ready:
  - in_ready = wr_ok && !(rd_ok && rr_last==WRITE).
  - in_ready does not depend on in_valid.
- Write grant = in_valid && in_ready. RAM signals are driven combinationally in the same cycle:
  - ram_cs[fill_sel]=1, ram_we[fill_sel]=1, ram_address=wr_cnt.
  - wr_cnt++.
  - On wr_cnt==FRAME_LEN-1: wr_cnt<=0, bank_full[fill_sel]<=1, fill_sel toggles.
- Read grant:
  - ram_cs[rd_sel]=1, ram_we=00, ram_address=rd_cnt.
  - rd_pend<=1 with bank and last tag (rd_cnt==FRAME_LEN-1).
  - On the last word: rd_cnt<=0, bank_full[rd_sel]<=0 at issue, rd_sel toggles.
- Read data path:
  - Next cycle, ram_data_out[tagged bank] and the last tag are pushed into the FIFO.
  - out_valid = FIFO non-empty; pop on out_valid && out_ready.
- Idle cycles: ram_cs=00, ram_we=00, ram_address holds its last value.
- Latency:
  - Read issue at cycle N -> out_valid at N+2.
  - Last write at N -> earliest read issue N+1 -> out_valid N+3.
- Set and clear of bank_full in the same cycle always hit different banks; both take effect.
- Both banks full: in_ready=0 until the drain of one bank has issued its last read. Writer back-pressure must not corrupt data.
- out_ready low: the credit check stops read issue; the FIFO never overflows; a pending read always lands in a free slot.
- Reset asserted mid-frame: partial frames are discarded and the next accepted word goes to bank 0 address 0.

Decomposition:
- Package dec_ram_ctrl_pkg:
  - typedef grant_t {GNT_WRITE, GNT_READ}.
  - localparam OUT_FIFO_DEPTH=2.
  - typedef bank_sel_t (1 bit).
- Sub-module dec_out_fifo: 2-entry FIFO, DATA_WIDTH+1 wide (data + last), synchronous active-low reset, push/pop/count.

Test Plan:
1. FRAME_LEN=4, write words 1,0,1,1 with in_valid continuous, out_ready=1.
   -> ram_we=01 at addresses 0..3, then bank_full=01.
   -> out stream 1,0,1,1 with out_last on the 4th word, first out_valid 3 cycles after the last write.
2. Continuous input of 3 frames with out_ready=1.
   -> Writes alternate banks 0,1,0; reads interleave with writes round-robin (never two grants in one cycle).
   -> All 12 words are output in order.
3. out_ready=0 while 2 frames are written.
   -> bank_full=11, in_ready=0, FIFO holds 2 words with no further read issue.
   -> On releasing out_ready, frame 1 then frame 2 are output intact, and in_ready rises after frame 1's last read issues.
4. Toggle out_ready randomly (0101...) during a drain.
   -> No lost or duplicated words; the FIFO never exceeds 2.
5. Assert rst_n=0 for one cycle after 2 of 4 words are written.
   -> bank_full=00, out_valid=0; next frame written starting at bank 0 address 0 and output correctly.
6. Both requesters eligible in the first contest after reset.
   -> Write is granted first, then alternates read/write every cycle while both stay eligible.
